// File: rtl/data_memory_responder.sv
// Default data memory for the load/store unit: byte-lane RAM with a fixed-latency read
// pipeline feeding a FWFT response FIFO, protected by credit-based request gating.
module data_memory_responder #(
   parameter int RS_ID_WIDTH = 5,
   parameter int MEM_WORDS   = 1024,
   parameter int LATENCY     = 2,
   parameter int RESP_DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   to_mem_valid,
   output logic                   to_mem_ready,
   input  logic [RS_ID_WIDTH-1:0] to_mem_rs_id,
   input  logic [4:0]             to_mem_reg_addr,
   input  logic [0:31]            mem_address,
   input  logic [0:3]             mem_write_en,
   input  logic [0:31]            mem_write_data,
   input  logic [0:3]             mem_read_en,
   output logic                   from_mem_valid,
   input  logic                   from_mem_ready,
   output logic [RS_ID_WIDTH-1:0] from_mem_rs_id,
   output logic [4:0]             from_mem_reg_addr,
   output logic [0:31]            mem_read_data
);

   localparam int AW     = $clog2(MEM_WORDS);
   localparam int PW     = $clog2(RESP_DEPTH);
   localparam int CW     = PW + 1;
   localparam int RESP_W = RS_ID_WIDTH + 5 + 32;

   logic [0:31]       ram_r [MEM_WORDS];
   logic [RESP_W-1:0] fifo_r [RESP_DEPTH];
   logic [PW-1:0]     rd_ptr_r;
   logic [PW-1:0]     wr_ptr_r;
   logic [CW-1:0]     count_r;
   logic [CW-1:0]     credit_r;
   logic [CW-1:0]     credit_next_s;
   logic              ready_r;
   logic [AW-1:0]     word_idx_s;
   logic              accept_s;
   logic              read_acc_s;
   logic              pop_s;
   logic [0:31]       merged_s;
   logic [0:31]       read_word_s;
   logic [RESP_W-1:0] resp_in_s;
   logic              push_valid_s;
   logic [RESP_W-1:0] push_resp_s;
   logic              unused_addr_s;

   assign word_idx_s    = mem_address[30-AW:29];
   assign unused_addr_s = ^{mem_address[0:29-AW], mem_address[30:31]};
   // rst term keeps an edge that coincides with reset assertion from writing
   assign accept_s      = rst & to_mem_valid & ready_r;
   assign read_acc_s    = accept_s & (|mem_read_en);
   assign pop_s         = (count_r != {CW{1'b0}}) & from_mem_ready;
   assign to_mem_ready  = ready_r;
   assign resp_in_s     = {to_mem_rs_id, to_mem_reg_addr, read_word_s};

   // Post-write view of the addressed word, then read-lane masking
   always_comb begin
      merged_s    = ram_r[word_idx_s];
      read_word_s = 32'h0000_0000;
      for (int i = 0; i < 4; i++) begin
         if (mem_write_en[i]) begin
            merged_s[8*i +: 8] = mem_write_data[8*i +: 8];
         end else begin
            merged_s[8*i +: 8] = ram_r[word_idx_s][8*i +: 8];
         end
         if (mem_read_en[i]) begin
            read_word_s[8*i +: 8] = merged_s[8*i +: 8];
         end else begin
            read_word_s[8*i +: 8] = 8'h00;
         end
      end
   end

   // RAM write port; contents are intentionally not reset
   always_ff @(posedge clk) begin
      if (accept_s && (|mem_write_en)) begin
         ram_r[word_idx_s] <= merged_s;
      end
   end

   generate
      if (LATENCY == 1) begin : g_direct
         assign push_valid_s = read_acc_s;
         assign push_resp_s  = resp_in_s;
      end else begin : g_pipe
         logic              pipe_v_r [LATENCY-1];
         logic [RESP_W-1:0] pipe_d_r [LATENCY-1];

         // Read shift pipeline; the last stage pushes into the FIFO
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int k = 0; k < LATENCY-1; k++) begin
                  pipe_v_r[k] <= 1'b0;
                  pipe_d_r[k] <= {RESP_W{1'b0}};
               end
            end else begin
               pipe_v_r[0] <= read_acc_s;
               pipe_d_r[0] <= resp_in_s;
               for (int k = 1; k < LATENCY-1; k++) begin
                  pipe_v_r[k] <= pipe_v_r[k-1];
                  pipe_d_r[k] <= pipe_d_r[k-1];
               end
            end
         end

         assign push_valid_s = pipe_v_r[LATENCY-2];
         assign push_resp_s  = pipe_d_r[LATENCY-2];
      end
   endgenerate

   // Response FIFO storage; credit guarantees a free slot on every push
   always_ff @(posedge clk) begin
      if (push_valid_s) begin
         fifo_r[wr_ptr_r] <= push_resp_s;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_valid_s) wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         if (pop_s)        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         case ({push_valid_s, pop_s})
            2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
      end
   end

   // Next credit: reads in flight plus queued responses
   always_comb begin
      case ({read_acc_s, pop_s})
         2'b10:   credit_next_s = credit_r + {{(CW-1){1'b0}}, 1'b1};
         2'b01:   credit_next_s = credit_r - {{(CW-1){1'b0}}, 1'b1};
         default: credit_next_s = credit_r;
      endcase
   end

   // Credit and registered request-ready
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credit_r <= {CW{1'b0}};
         ready_r  <= 1'b0;
      end else begin
         credit_r <= credit_next_s;
         ready_r  <= (credit_next_s < CW'(RESP_DEPTH));
      end
   end

   // Head-of-FIFO presentation, zeroed when empty
   always_comb begin
      if (count_r != {CW{1'b0}}) begin
         from_mem_valid = 1'b1;
         {from_mem_rs_id, from_mem_reg_addr, mem_read_data} = fifo_r[rd_ptr_r];
      end else begin
         from_mem_valid    = 1'b0;
         from_mem_rs_id    = {RS_ID_WIDTH{1'b0}};
         from_mem_reg_addr = 5'd0;
         mem_read_data     = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed and scoreboarded checks of data_memory_responder with default parameters.
module tb_data_memory_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        to_mem_valid;
   logic        to_mem_ready;
   logic [4:0]  to_mem_rs_id;
   logic [4:0]  to_mem_reg_addr;
   logic [31:0] mem_address;
   logic [3:0]  mem_write_en;
   logic [31:0] mem_write_data;
   logic [3:0]  mem_read_en;
   logic        from_mem_valid;
   logic        from_mem_ready;
   logic [4:0]  from_mem_rs_id;
   logic [4:0]  from_mem_reg_addr;
   logic [31:0] mem_read_data;

   int checks = 0;
   int errors = 0;

   data_memory_responder dut (
      .clk(clk), .rst(rst),
      .to_mem_valid(to_mem_valid), .to_mem_ready(to_mem_ready),
      .to_mem_rs_id(to_mem_rs_id), .to_mem_reg_addr(to_mem_reg_addr),
      .mem_address(mem_address), .mem_write_en(mem_write_en),
      .mem_write_data(mem_write_data), .mem_read_en(mem_read_en),
      .from_mem_valid(from_mem_valid), .from_mem_ready(from_mem_ready),
      .from_mem_rs_id(from_mem_rs_id), .from_mem_reg_addr(from_mem_reg_addr),
      .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic v, input logic [31:0] a, input logic [3:0] we,
                          input logic [31:0] wd, input logic [3:0] re,
                          input logic [4:0] id, input logic [4:0] rg);
      to_mem_valid    = v;
      mem_address     = a;
      mem_write_en    = we;
      mem_write_data  = wd;
      mem_read_en     = re;
      to_mem_rs_id    = id;
      to_mem_reg_addr = rg;
   endtask

   task automatic idle();
      set_req(1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 5'd0, 5'd0);
   endtask

   task automatic pop_one();
      from_mem_ready = 1'b1;
      tick();
      from_mem_ready = 1'b0;
   endtask

   // Lane i (bit i of a big-endian enable) is byte [31-8i -: 8] of the word
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (we[3-i]) r[31-8*i -: 8] = wd[31-8*i -: 8];
      return r;
   endfunction

   function automatic logic [31:0] mask(input logic [31:0] w, input logic [3:0] re);
      logic [31:0] r;
      r = 32'h0;
      for (int i = 0; i < 4; i++) if (re[3-i]) r[31-8*i -: 8] = w[31-8*i -: 8];
      return r;
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      from_mem_ready = 1'b0;
      idle();
      tick(); tick(); tick();
      checks++;
      if ({to_mem_ready, from_mem_valid, from_mem_rs_id, from_mem_reg_addr, mem_read_data} !== 44'h0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b vld=%b id=%h reg=%h data=%h want all 0",
                  to_mem_ready, from_mem_valid, from_mem_rs_id, from_mem_reg_addr, mem_read_data);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (to_mem_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_release got %b want 1", to_mem_ready);
      end
   endtask

   task automatic test_write_read();
      set_req(1'b1, 32'h100, 4'b1111, 32'hDEADBEEF, 4'b0000, 5'd0, 5'd0);
      tick();
      set_req(1'b1, 32'h100, 4'b0000, 32'h0, 4'b1111, 5'd3, 5'd7);
      checks++;
      if (from_mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL store_no_resp got %b want 0", from_mem_valid);
      end
      tick();
      idle();
      checks++;
      if (from_mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL read_latency_early got %b want 0", from_mem_valid);
      end
      tick();
      checks++;
      if ({from_mem_valid, from_mem_rs_id, from_mem_reg_addr, mem_read_data} !== {1'b1, 5'd3, 5'd7, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL write_read got vld=%b id=%0d reg=%0d data=%h want 1/3/7/deadbeef",
                  from_mem_valid, from_mem_rs_id, from_mem_reg_addr, mem_read_data);
      end
      pop_one();
      checks++;
      if (from_mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL pop_empties got %b want 0", from_mem_valid);
      end
   endtask

   task automatic test_byte_lanes();
      set_req(1'b1, 32'h40, 4'b1111, 32'h11223344, 4'b0000, 5'd0, 5'd0);
      tick();
      set_req(1'b1, 32'h40, 4'b0100, 32'hAABBCCDD, 4'b0000, 5'd0, 5'd0);
      tick();
      set_req(1'b1, 32'h40, 4'b0000, 32'h0, 4'b0110, 5'd1, 5'd2);
      tick(); idle(); tick();
      checks++;
      if ({from_mem_valid, mem_read_data} !== {1'b1, 32'h00BB3300}) begin
         errors++;
         $display("FAIL lane_mask got vld=%b data=%h want 1/00bb3300", from_mem_valid, mem_read_data);
      end
      pop_one();
      set_req(1'b1, 32'h43, 4'b0000, 32'h0, 4'b1111, 5'd2, 5'd3);
      tick(); idle(); tick();
      checks++;
      if ({from_mem_valid, from_mem_rs_id, mem_read_data} !== {1'b1, 5'd2, 32'h11BB3344}) begin
         errors++;
         $display("FAIL lane_write_low_addr got vld=%b id=%0d data=%h want 1/2/11bb3344",
                  from_mem_valid, from_mem_rs_id, mem_read_data);
      end
      pop_one();
   endtask

   task automatic test_backpressure();
      int next = 0;
      int got  = 0;
      logic [4:0] ids [6];
      from_mem_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         set_req(1'b1, 32'h100, 4'b0000, 32'h0, 4'b1111, next[4:0], 5'd9);
         if (to_mem_ready) next++;
         tick();
      end
      checks++;
      if (next !== 4 || to_mem_ready !== 1'b0) begin
         errors++;
         $display("FAIL credit_limit got accepted=%0d rdy=%b want 4/0", next, to_mem_ready);
      end
      from_mem_ready = 1'b1;
      for (int c = 0; c < 40 && got < 6; c++) begin
         if (from_mem_valid) begin
            ids[got] = from_mem_rs_id;
            checks++;
            if (mem_read_data !== 32'hDEADBEEF) begin
               errors++;
               $display("FAIL bp_data got %h want deadbeef", mem_read_data);
            end
            got++;
         end
         if (next < 6) begin
            set_req(1'b1, 32'h100, 4'b0000, 32'h0, 4'b1111, next[4:0], 5'd9);
            if (to_mem_ready) next++;
         end else begin
            idle();
         end
         tick();
      end
      from_mem_ready = 1'b0;
      idle();
      checks++;
      if (got !== 6) begin
         errors++;
         $display("FAIL bp_count got %0d want 6", got);
      end
      for (int i = 0; i < got; i++) begin
         checks++;
         if (ids[i] !== 5'(i)) begin
            errors++;
            $display("FAIL bp_order idx %0d got %0d want %0d", i, ids[i], i);
         end
      end
   endtask

   task automatic test_combined();
      logic seen = 1'b0;
      set_req(1'b1, 32'h200, 4'b1111, 32'h12345678, 4'b1111, 5'd9, 5'd4);
      tick(); idle(); tick();
      checks++;
      if ({from_mem_valid, from_mem_rs_id, from_mem_reg_addr, mem_read_data} !== {1'b1, 5'd9, 5'd4, 32'h12345678}) begin
         errors++;
         $display("FAIL combined got vld=%b id=%0d reg=%0d data=%h want 1/9/4/12345678",
                  from_mem_valid, from_mem_rs_id, from_mem_reg_addr, mem_read_data);
      end
      pop_one();
      set_req(1'b1, 32'h200, 4'b1111, 32'h0BADF00D, 4'b0000, 5'd1, 5'd1);
      tick(); idle();
      for (int c = 0; c < 5; c++) begin
         if (from_mem_valid) seen = 1'b1;
         tick();
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL store_only_pulse got %b want 0", seen);
      end
   endtask

   task automatic test_traffic();
      logic [31:0] mdl [8];
      logic [41:0] exp_q [$];
      logic [41:0] head, prev_head;
      logic        prev_hold = 1'b0;
      logic        v, rdy;
      logic [3:0]  we, re;
      logic [31:0] wd, a, nw;
      logic [4:0]  id, rg;
      int          accepted = 0;
      int          k;
      for (int i = 0; i < 8; i++) begin
         mdl[i] = 32'hA5000000 + 32'(i * 32'h01010101);
         set_req(1'b1, 32'h300 + 32'(4*i), 4'b1111, mdl[i], 4'b0000, 5'd0, 5'd0);
         tick();
      end
      idle();
      for (int cyc = 0; cyc < 3000 && accepted < 64; cyc++) begin
         head = {from_mem_rs_id, from_mem_reg_addr, mem_read_data};
         if (from_mem_valid) begin
            checks++;
            if (exp_q.size() == 0 || head !== exp_q[0]) begin
               errors++;
               $display("FAIL traffic_head got %h want %h", head,
                        (exp_q.size() == 0) ? 42'h0 : exp_q[0]);
            end
         end
         if (prev_hold) begin
            checks++;
            if ({from_mem_valid, head} !== {1'b1, prev_head}) begin
               errors++;
               $display("FAIL traffic_stable got %b/%h want 1/%h", from_mem_valid, head, prev_head);
            end
         end
         checks++;
         if (to_mem_ready !== (exp_q.size() < 4)) begin
            errors++;
            $display("FAIL traffic_credit got rdy=%b want %b (outstanding %0d)",
                     to_mem_ready, exp_q.size() < 4, exp_q.size());
         end
         rdy = 1'($urandom_range(0, 1));
         from_mem_ready = rdy;
         v  = ($urandom_range(0, 9) < 8);
         k  = $urandom_range(0, 7);
         a  = 32'h300 + 32'(4*k) + 32'($urandom_range(0, 3));
         we = 4'($urandom_range(0, 15));
         re = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) we = 4'b0000;
         wd = $urandom;
         id = 5'($urandom_range(0, 31));
         rg = 5'($urandom_range(0, 31));
         set_req(v, a, we, wd, re, id, rg);
         if (from_mem_valid && rdy && exp_q.size() > 0) void'(exp_q.pop_front());
         if (v && to_mem_ready) begin
            nw = merge(mdl[k], wd, we);
            mdl[k] = nw;
            if (re != 4'b0000) exp_q.push_back({id, rg, mask(nw, re)});
            accepted++;
         end
         prev_hold = from_mem_valid && !rdy;
         prev_head = head;
         tick();
      end
      checks++;
      if (accepted !== 64) begin
         errors++;
         $display("FAIL traffic_budget got %0d accepted want 64", accepted);
      end
      idle();
      from_mem_ready = 1'b1;
      for (int c = 0; c < 50 && (exp_q.size() > 0 || from_mem_valid); c++) begin
         head = {from_mem_rs_id, from_mem_reg_addr, mem_read_data};
         if (from_mem_valid) begin
            checks++;
            if (exp_q.size() == 0 || head !== exp_q[0]) begin
               errors++;
               $display("FAIL drain_head got %h want %h", head,
                        (exp_q.size() == 0) ? 42'h0 : exp_q[0]);
            end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
         tick();
      end
      from_mem_ready = 1'b0;
      checks++;
      if (exp_q.size() != 0 || from_mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_empty got left=%0d vld=%b want 0/0", exp_q.size(), from_mem_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic seen = 1'b0;
      set_req(1'b1, 32'h80, 4'b1111, 32'hCAFEF00D, 4'b0000, 5'd0, 5'd0);
      tick();
      from_mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_req(1'b1, 32'h80, 4'b0000, 32'h0, 4'b1111, 5'(20 + i), 5'd1);
         tick();
      end
      idle();
      tick();
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({to_mem_ready, from_mem_valid, from_mem_rs_id, from_mem_reg_addr, mem_read_data} !== 44'h0) begin
         errors++;
         $display("FAIL async_reset got rdy=%b vld=%b id=%h reg=%h data=%h want all 0",
                  to_mem_ready, from_mem_valid, from_mem_rs_id, from_mem_reg_addr, mem_read_data);
      end
      tick(); tick();
      rst = 1'b1;
      from_mem_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (from_mem_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL stale_response got %b want 0", seen);
      end
      from_mem_ready = 1'b0;
      set_req(1'b1, 32'h80, 4'b0000, 32'h0, 4'b1111, 5'd5, 5'd6);
      tick(); idle(); tick();
      checks++;
      if ({from_mem_valid, from_mem_rs_id, mem_read_data} !== {1'b1, 5'd5, 32'hCAFEF00D}) begin
         errors++;
         $display("FAIL ram_survives_reset got vld=%b id=%0d data=%h want 1/5/cafef00d",
                  from_mem_valid, from_mem_rs_id, mem_read_data);
      end
      pop_one();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_backpressure();
      test_combined();
      test_traffic();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Responder end of the load/store unit's memory protocol: accepts `to_mem_*` requests, performs byte-lane writes and reads on an internal word-addressed data RAM, and returns read results on the `from_mem_*` interface in request order. It sits between the load/store wrapper and the top-level memory map as the default data memory for simulation and small FPGA builds. A fixed-latency read pipeline feeds a response FIFO, and credit-based flow control guarantees that no accepted read is ever dropped under `from_mem_ready` backpressure.

## Interface
- `RS_ID_WIDTH`, 5, width of the reservation-station ID carried with each request.
- `MEM_WORDS`, 1024, number of 32-bit words in the RAM; power of two, ≥ 4.
- `LATENCY`, 2, cycles from request acceptance to response availability; ≥ 1.
- `RESP_DEPTH`, 4, response FIFO depth and maximum outstanding reads; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `to_mem_valid`  in  1  request valid.
- `to_mem_ready`  out  1  request accepted when high together with valid.
- `to_mem_rs_id`  in  RS_ID_WIDTH  tag returned with the response.
- `to_mem_reg_addr`  in  5  destination GPR, returned with the response.
- `mem_address`  in  32  byte address; bits [30:31] ignored.
- `mem_write_en`  in  4  byte-lane write enables; lane 0 = bits [0:7].
- `mem_write_data`  in  32  write data, big-endian lanes.
- `mem_read_en`  in  4  byte-lane read enables.
- `from_mem_valid`  out  1  response valid.
- `from_mem_ready`  in  1  response consumed when high together with valid.
- `from_mem_rs_id`  out  RS_ID_WIDTH  tag of the head response.
- `from_mem_reg_addr`  out  5  GPR address of the head response.
- `mem_read_data`  out  32  read data of the head response.

## Operation
- **Word index:** `mem_address[0:29]` modulo `MEM_WORDS`, taking the low `log2(MEM_WORDS)` bits of the word address.
- **Acceptance:** a request is accepted on a rising edge where `to_mem_valid && to_mem_ready`.
- **Write:** on acceptance, each lane i with `mem_write_en[i]=1` updates byte i of the addressed word. Other lanes are untouched.
- **Read:** a request is a read if `mem_read_en != 0`. The word is sampled at the acceptance edge, after that request's own write is applied, so a combined write+read returns the post-write value. Lanes with `mem_read_en[i]=0` are returned as 0x00. No alignment or sign extension is done here; the load/store unit handles that.
- **Pure stores** (`mem_read_en=0`) produce no response.
- **Requests with both enables 0** are accepted and produce no effect and no response.
- **Read pipeline:** read responses enter a `LATENCY`-stage valid/tag/data shift pipeline, then a `RESP_DEPTH`-entry first-word-fall-through FIFO. Responses leave in acceptance order.
- **Credit counter** = reads in the pipeline + FIFO occupancy.
  - `to_mem_ready = (credit < RESP_DEPTH)`. It depends only on registered state, never combinationally on `to_mem_valid` or `from_mem_ready`.
  - All request types are gated by `to_mem_ready`.
  - Credit increments on read acceptance and decrements on response pop. When both happen in the same cycle, credit is unchanged.
- **Outputs:** `from_mem_valid` = FIFO not empty. `from_mem_rs_id`, `from_mem_reg_addr` and `mem_read_data` show the head entry, and are 0 when the FIFO is empty.
- **RAM contents** are not reset; they are undefined until written.

## Timing
- **Reset values:** while `rst=0` and after release:
  - `to_mem_ready=0` during reset, 1 from the first cycle after release.
  - `from_mem_valid=0`, `from_mem_rs_id=0`, `from_mem_reg_addr=0`, `mem_read_data=0`.
  - Pipeline, FIFO pointers and credit are cleared.
- **Read latency:** a read accepted at edge N has `from_mem_valid` high in the cycle after edge N+LATENCY-1, provided no older responses are queued. With `LATENCY=1`, it is valid in the cycle directly after acceptance.
- **Throughput:** one request per cycle while credit allows. With `from_mem_ready` held high, sustained reads run at 1/cycle only if `RESP_DEPTH ≥ LATENCY+1`; otherwise ready deasserts periodically. This is legal but lowers throughput.
- **Backpressure:** while `from_mem_ready=0`, the head response holds stable: valid, tag and data do not change. After `RESP_DEPTH` outstanding reads, `to_mem_ready=0` until a pop.
- **Full FIFO with pop and push in the same edge:** legal, and no entry is lost. The pipeline never stalls, because credit guarantees space.
- **Pointer wrap:** FIFO pointers wrap modulo `RESP_DEPTH`, with an explicit count or extra pointer bit to distinguish full from empty.
- **Reset asserted mid-operation:**
  - In-flight and queued reads are discarded, with no response after release.
  - Writes accepted before reset remain in RAM.
  - An edge coinciding with reset assertion performs no write.

## Test plan
1. **Write then read:** reset, then write 0xDEADBEEF to 0x100 with `mem_write_en=1111`, then read 0x100 with `mem_read_en=1111`, rs_id 3, reg 7. Required: response 0xDEADBEEF / id 3 / reg 7 exactly LATENCY cycles after the read acceptance.
2. **Byte lanes:**
   - Write 0xAABBCCDD to 0x40 with `mem_write_en=0100`, over a prior 0x11223344.
   - Read 0x40 with `mem_read_en=0110`.
   - Required: 0x00BB3300.
   - A read at 0x43 with `mem_read_en=1111` returns 0x11BB3344, since the low address bits are ignored.
3. **Backpressure/credit:** hold `from_mem_ready=0` and issue 6 reads back-to-back with ids 0..5. Required:
   - Exactly `RESP_DEPTH`=4 are accepted, and `to_mem_ready` drops after the 4th.
   - After releasing ready, responses come in order with ids 0,1,2,3.
   - The remaining 2 reads are then accepted and returned as ids 4, 5.
4. **Combined write+read** to 0x200 (write 0x12345678, both enables 1111). Required: response 0x12345678. A store-only request produces no `from_mem_valid` pulse.
5. **Sustained traffic:** 64 random reads/writes with a random `from_mem_ready` toggle, checked against a scoreboard. Required:
   - Order, tags and data all match.
   - Credit never exceeds `RESP_DEPTH`.
   - The head response is stable whenever valid is high and ready is low.
6. **Reset mid-stream:** pull `rst` low with 3 reads outstanding. Required:
   - Outputs go to their reset values asynchronously.
   - No stale response appears after release.
   - A prior write to 0x80 still reads back correctly.
